// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared widths, FSM encoding and address range helper for the data-memory responder
package sisc_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when the word address falls inside the 2^depth_log2 implemented words.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth_log2);
        return (32'(addr) >> depth_log2) == 32'd0;
    endfunction

endpackage

// File: rtl/dm_array.sv
// rtl/dm_array.sv - single-port word storage with synchronous write and registered read
module dm_array
    import sisc_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dm_resp.sv
// rtl/dm_resp.sv - data-memory responder: request capture, wait-state FSM, range check, one-cycle response
module dm_resp
    import sisc_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [3:0]        cnt_next;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              accept;
    logic              access;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_in_range;
    logic [DATA_W-1:0] arr_rdata;

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
        end
    end

    // With no wait states the access happens on the accept edge itself, straight from the request inputs.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access     = 1'b0;
        acc_we     = cap_we;
        acc_addr   = cap_addr;
        acc_wdata  = cap_wdata;
        case (state)
            ST_IDLE: begin
                if (req_valid && !rst_f) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        access     = 1'b1;
                        acc_we     = req_we;
                        acc_addr   = req_addr;
                        acc_wdata  = req_wdata;
                        state_next = ST_RESP;
                    end else begin
                        cnt_next   = CNT_LOAD;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    access     = !rst_f;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign acc_in_range = addr_in_range(acc_addr, DEPTH_LOG2);

    dm_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (access && acc_we && acc_in_range),
        .re   (access && !acc_we),
        .addr (acc_addr[DEPTH_LOG2-1:0]),
        .wdata(acc_wdata),
        .rdata(arr_rdata)
    );

    assign req_ready = !rst_f && (state == ST_IDLE);
    assign rsp_valid = !rst_f && (state == ST_RESP);
    assign rsp_err   = rsp_valid && !addr_in_range(cap_addr, DEPTH_LOG2);
    assign rsp_rdata = (rsp_valid && !cap_we && !rsp_err) ? arr_rdata : '0;

endmodule

// File: tb/tb_dm_resp.sv
// tb/tb_dm_resp.sv - directed self-checking bench for dm_resp with two wait-state configurations
module tb_dm_resp;

    logic        clk;
    logic        rst_f;

    logic        a_valid, a_we, a_ready, a_rsp_valid, a_err;
    logic [15:0] a_addr;
    logic [31:0] a_wdata, a_rdata;

    logic        b_valid, b_we, b_ready, b_rsp_valid, b_err;
    logic [15:0] b_addr;
    logic [31:0] b_wdata, b_rdata;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        seen;
    logic [7:0]  vpat, rpat;

    dm_resp #(.WAIT_STATES(2), .DEPTH_LOG2(10)) dut_a (
        .clk(clk), .rst_f(rst_f),
        .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
        .req_ready(a_ready), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err)
    );

    dm_resp #(.WAIT_STATES(0), .DEPTH_LOG2(4)) dut_b (
        .clk(clk), .rst_f(rst_f),
        .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
        .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on dut_a, scramble the request inputs after accept, and wait for the response.
    task automatic a_req(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdo, output logic erro, output int lato);
        int t;
        t = 0;
        while (!a_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        @(posedge clk); #1;
        a_valid = 1'b0; a_we = ~we; a_addr = addr ^ 16'h0003; a_wdata = ~wd;
        lato = 0;
        while (!a_rsp_valid && lato < 20) begin
            @(posedge clk); #1;
            lato++;
        end
        rdo  = a_rdata;
        erro = a_err;
        @(posedge clk); #1;
        check("pulse_one_cycle", {29'd0, a_rsp_valid, a_err, a_ready}, 32'd1);
        check("rdata_idle_zero", a_rdata, 32'd0);
    endtask

    initial begin
        clk = 1'b0; rst_f = 1'b1;
        a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_a_ctl", {29'd0, a_ready, a_rsp_valid, a_err}, 32'd0);
            check("rst_a_rdata", a_rdata, 32'd0);
            check("rst_b_ctl", {29'd0, b_ready, b_rsp_valid, b_err}, 32'd0);
        end
        rst_f = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst_a", {31'd0, a_ready}, 32'd1);
        check("ready_after_rst_b", {31'd0, b_ready}, 32'd1);

        a_req(1'b1, 16'h0005, 32'hDEADBEEF, rd, er, lat);
        check("wr5_latency", lat, 32'd2);
        check("wr5_err", {31'd0, er}, 32'd0);
        check("wr5_rdata", rd, 32'd0);
        a_req(1'b0, 16'h0005, 32'h0, rd, er, lat);
        check("rd5_latency", lat, 32'd2);
        check("rd5_rdata", rd, 32'hDEADBEEF);
        check("rd5_err", {31'd0, er}, 32'd0);

        a_req(1'b1, 16'h0000, 32'h11112222, rd, er, lat);
        check("wr0_err", {31'd0, er}, 32'd0);
        a_req(1'b1, 16'h0400, 32'h12345678, rd, er, lat);
        check("wr400_err", {31'd0, er}, 32'd1);
        check("wr400_rdata", rd, 32'd0);
        check("wr400_latency", lat, 32'd2);
        a_req(1'b0, 16'h0000, 32'h0, rd, er, lat);
        check("rd0_after_oor", rd, 32'h11112222);
        a_req(1'b0, 16'h0400, 32'h0, rd, er, lat);
        check("rd400_rdata", rd, 32'd0);
        check("rd400_err", {31'd0, er}, 32'd1);

        a_req(1'b1, 16'h0007, 32'hCAFEF00D, rd, er, lat);
        a_req(1'b0, 16'h0007, 32'h0, rd, er, lat);
        check("rd7_captured", rd, 32'hCAFEF00D);

        a_req(1'b1, 16'h0003, 32'h01020304, rd, er, lat);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 16'h0003; a_wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        a_valid = 1'b0;
        rst_f = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            seen = seen | a_rsp_valid;
        end
        rst_f = 1'b0;
        #1;
        check("ready_after_midrst", {31'd0, a_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | a_rsp_valid;
        end
        check("no_rsp_after_abort", {31'd0, seen}, 32'd0);
        a_req(1'b0, 16'h0003, 32'h0, rd, er, lat);
        check("rd3_prior_contents", rd, 32'h01020304);

        b_valid = 1'b1; b_we = 1'b1; b_addr = 16'h0001; b_wdata = 32'h000000A1;
        vpat = '0; rpat = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            b_we = 1'b0;
            vpat[i] = b_rsp_valid;
            rpat[i] = b_ready;
            if (b_rsp_valid && i == 0) check("b_wr_rdata", b_rdata, 32'd0);
            if (b_rsp_valid && i > 0) check("b_rd_rdata", b_rdata, 32'h000000A1);
        end
        b_valid = 1'b0;
        check("b_valid_pattern", {24'd0, vpat}, 32'h00000055);
        check("b_ready_pattern", {24'd0, rpat}, 32'h000000AA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 Parameter WAIT_STATES, default 2: idle cycles inserted between request accept and memory access (legal 0..15).
REQ-002 Parameter DEPTH_LOG2, default 10: implemented words = 2^DEPTH_LOG2; legal 1..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_f  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  processor presents a data-memory request.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  16  word address.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  read data, valid only while rsp_valid=1.
REQ-012 rsp_err  output  1  access was out of range, valid only while rsp_valid=1.

Function
REQ-013 FSM states IDLE, WAIT, RESP; one request outstanding at most.
REQ-014 IDLE: req_ready=1; req_valid=1 accepts the request, capturing req_we/req_addr/req_wdata into internal registers.
REQ-015 On accept: WAIT_STATES>0 -> WAIT with down-counter loaded WAIT_STATES-1; WAIT_STATES=0 -> access in the next cycle, entering RESP.
REQ-016 WAIT: req_ready=0; counter decrements each cycle; at count 0 the access executes and FSM -> RESP.
REQ-017 Access: write stores captured data at captured address; read registers the array word into rsp_rdata.
REQ-018 RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then -> IDLE; no back-pressure on response.
REQ-019 Latency: request accepted on edge N -> rsp_valid high in cycle N+WAIT_STATES+1; next accept no earlier than edge N+WAIT_STATES+2.
REQ-020 Write response: rsp_valid=1, rsp_rdata=0, rsp_err=0.
REQ-021 Out-of-range (req_addr >= 2^DEPTH_LOG2): no array write, rsp_rdata=0, rsp_err=1, same latency.
REQ-022 Inputs ignored while req_ready=0; changes to req_* after accept do not affect the in-flight access.
REQ-023 Read of a word written by any earlier completed write returns the new value (no stale data).
REQ-024 rsp_rdata and rsp_err hold 0 whenever rsp_valid=0.

Reset
REQ-025 While rst_f=1: state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-026 First cycle after rst_f falls: req_ready=1.
REQ-027 Reset mid-operation abandons the request: uncommitted write never reaches the array; no rsp_valid is issued.
REQ-028 Array contents are not cleared by reset.

Structure
REQ-029 Shared package sisc_pkg holds FSM state encoding, data width 32, address width 16.
REQ-030 Storage is a separate sub-module dm_array (synchronous write, registered read, one port); dm_resp holds FSM, counter, capture registers, range check.

Verification
REQ-031 WAIT_STATES=2: write addr 0x0005 data 0xDEADBEEF accepted edge 10 -> rsp_valid only in cycle 13, rsp_err=0; then read 0x0005 -> rsp_rdata=0xDEADBEEF.
REQ-032 WAIT_STATES=0: back-to-back reads with req_valid held 1 -> accepts every 2 cycles, rsp_valid every 2 cycles.
REQ-033 DEPTH_LOG2=10: write 0x0400 data 0x12345678 -> rsp_err=1; read 0x0000 still returns its previous value; read 0x0400 -> rsp_rdata=0, rsp_err=1.
REQ-034 Change req_addr/req_wdata during WAIT -> stored word equals values captured at accept.
REQ-035 Assert rst_f during WAIT of write to 0x0003 (0xAAAA5555) -> no rsp_valid; read 0x0003 after reset returns prior contents.
REQ-036 Reset for 3 cycles -> all outputs 0 throughout; req_ready=1 on first cycle after release.
